// File: rtl/fft_feeder_pkg.sv
// Shared types and constants for the FFT sink-side frame feeder.
package fft_feeder_pkg;

  localparam int unsigned DW_DEF     = 14;
  localparam int unsigned PW_DEF     = 11;
  localparam int unsigned FFTPTS_MIN = 8;
  localparam int unsigned FFTPTS_MAX = 1024;

  typedef struct packed {
    logic signed [DW_DEF-1:0] re;
    logic signed [DW_DEF-1:0] im;
    logic                     sop;
    logic                     eop;
    logic [PW_DEF-1:0]        pts;
    logic                     inv;
  } fft_word_t;

  function automatic logic is_legal_pts(input logic [31:0] pts);
    return ($countones(pts) == 1) && (pts >= FFTPTS_MIN) && (pts <= FFTPTS_MAX);
  endfunction

endpackage

// File: rtl/fft_skid_buf.sv
// Two-entry ready/valid register slice: output register plus one skid entry.
module fft_skid_buf
  import fft_feeder_pkg::*;
#(
  parameter type   word_t   = fft_word_t,
  parameter word_t RST_WORD = '0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push_i,
  input  word_t data_i,
  input  logic  ready_i,
  output logic  valid_o,
  output word_t data_o,
  output logic  full_nxt_o,
  output logic  empty_nxt_o
);

  word_t out_q, out_d, skid_q, skid_d;
  logic  out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic  load_out;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    load_out   = !out_vld_q || ready_i;

    if (load_out) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = push_i;
        if (push_i) skid_d = data_i;
      end else begin
        // Data is kept on an empty drain so the sink_* lines do not toggle needlessly.
        out_vld_d = push_i;
        if (push_i) out_d = data_i;
      end
    end else if (push_i) begin
      skid_d     = data_i;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= RST_WORD;
      out_vld_q  <= 1'b0;
      skid_q     <= RST_WORD;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign valid_o     = out_vld_q;
  assign data_o      = out_q;
  assign full_nxt_o  = out_vld_d && skid_vld_d;
  assign empty_nxt_o = !out_vld_d && !skid_vld_d;

endmodule

// File: rtl/fft_frame_feeder.sv
// Packetizes a continuous complex sample stream into framed Avalon-ST words for the fft core.
module fft_frame_feeder
  import fft_feeder_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned PW = PW_DEF,
  parameter int unsigned CW = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [PW-1:0]        cfg_fftpts,
  input  logic                 cfg_inverse,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_real,
  input  logic signed [DW-1:0] in_imag,
  output logic                 sink_valid,
  input  logic                 sink_ready,
  output logic [1:0]           sink_error,
  output logic                 sink_sop,
  output logic                 sink_eop,
  output logic signed [DW-1:0] sink_real,
  output logic signed [DW-1:0] sink_imag,
  output logic [PW-1:0]        fftpts_in,
  output logic                 inverse,
  output logic                 cfg_err,
  output logic [CW-1:0]        frame_cnt,
  output logic                 busy
);

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic                 sop;
    logic                 eop;
    logic [PW-1:0]        pts;
    logic                 inv;
  } word_t;

  typedef enum logic {IDLE, STREAM} state_e;

  localparam word_t RST_WORD = '{re: '0, im: '0, sop: 1'b0, eop: 1'b0,
                                 pts: PW'(FFTPTS_MAX), inv: 1'b0};

  state_e        state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pts_q, pts_d;
  logic          inv_q, inv_d;
  logic          in_ready_q, in_ready_d;
  logic          cfg_err_q, cfg_err_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;

  logic  cfg_legal, push, pop, full_nxt, empty_nxt, out_valid;
  word_t word_in, word_out;

  assign cfg_legal = is_legal_pts(32'(cfg_fftpts));
  assign push      = in_valid && in_ready_q;
  assign pop       = out_valid && sink_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pts_d   = pts_q;
    inv_d   = inv_q;
    word_in = '{re: in_real, im: in_imag, sop: 1'b0, eop: 1'b0, pts: pts_q, inv: inv_q};

    if (push) begin
      case (state_q)
        IDLE: begin
          // A config that turns illegal on the very cycle of an accept keeps the previous frame's settings.
          if (cfg_legal) begin
            pts_d = cfg_fftpts;
            inv_d = cfg_inverse;
          end
          word_in.sop = 1'b1;
          word_in.pts = pts_d;
          word_in.inv = inv_d;
          cnt_d       = PW'(1);
          state_d     = STREAM;
        end
        STREAM: begin
          word_in.eop = (cnt_q + PW'(1)) == pts_q;
          if (word_in.eop) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + PW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    cfg_err_d   = (state_d == IDLE) && !cfg_legal;
    in_ready_d  = !full_nxt && !cfg_err_d;
    busy_d      = (state_d == STREAM) || !empty_nxt;
    frame_cnt_d = frame_cnt_q + CW'(pop && word_out.eop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pts_q       <= PW'(FFTPTS_MAX);
      inv_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pts_q       <= pts_d;
      inv_q       <= inv_d;
      in_ready_q  <= in_ready_d;
      cfg_err_q   <= cfg_err_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  fft_skid_buf #(
    .word_t   (word_t),
    .RST_WORD (RST_WORD)
  ) u_skid (
    .clk         (clk),
    .rst_n       (reset_n),
    .push_i      (push),
    .data_i      (word_in),
    .ready_i     (sink_ready),
    .valid_o     (out_valid),
    .data_o      (word_out),
    .full_nxt_o  (full_nxt),
    .empty_nxt_o (empty_nxt)
  );

  assign in_ready   = in_ready_q;
  assign sink_valid = out_valid;
  assign sink_error = '0;
  assign sink_sop   = word_out.sop;
  assign sink_eop   = word_out.eop;
  assign sink_real  = word_out.re;
  assign sink_imag  = word_out.im;
  assign fftpts_in  = word_out.pts;
  assign inverse    = word_out.inv;
  assign cfg_err    = cfg_err_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Randomized self-checking bench for fft_frame_feeder against a frame-level queue model.
module tb_fft_frame_feeder;

  localparam int DW = 14;
  localparam int PW = 11;
  localparam int CW = 16;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [PW-1:0]        cfg_fftpts;
  logic                 cfg_inverse;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_real, in_imag;
  logic                 sink_valid;
  logic                 sink_ready;
  logic [1:0]           sink_error;
  logic                 sink_sop, sink_eop;
  logic signed [DW-1:0] sink_real, sink_imag;
  logic [PW-1:0]        fftpts_in;
  logic                 inverse;
  logic                 cfg_err;
  logic [CW-1:0]        frame_cnt;
  logic                 busy;

  fft_frame_feeder #(.DW(DW), .PW(PW), .CW(CW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_fftpts  (cfg_fftpts),
    .cfg_inverse (cfg_inverse),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_real     (in_real),
    .in_imag     (in_imag),
    .sink_valid  (sink_valid),
    .sink_ready  (sink_ready),
    .sink_error  (sink_error),
    .sink_sop    (sink_sop),
    .sink_eop    (sink_eop),
    .sink_real   (sink_real),
    .sink_imag   (sink_imag),
    .fftpts_in   (fftpts_in),
    .inverse     (inverse),
    .cfg_err     (cfg_err),
    .frame_cnt   (frame_cnt),
    .busy        (busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          sop;
    logic          eop;
    logic [PW-1:0] pts;
    logic          inv;
  } exp_t;

  exp_t q[$];
  int   pos = 0;
  int   cur_len = 1;
  logic cur_inv = 1'b0;
  int   frames_seen = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   rdy_mode = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: every accepted sample becomes one expected output word, framed by position.
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      pos         = 0;
      frames_seen = 0;
    end else begin
      exp_t w;
      check("sink_valid", 64'(sink_valid), 64'(q.size() > 0));
      if (q.size() >= 2) check("in_ready_full", 64'(in_ready), 64'd0);
      if (sink_valid && q.size() > 0) begin
        check("word", 64'({sink_real, sink_imag, sink_sop, sink_eop, fftpts_in, inverse}), 64'(q[0]));
        if (sink_ready) begin
          if (q[0].eop) frames_seen++;
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        if (pos == 0) begin
          cur_len = int'(cfg_fftpts);
          cur_inv = cfg_inverse;
        end
        w.re  = in_real;
        w.im  = in_imag;
        w.sop = (pos == 0);
        w.eop = (pos == cur_len - 1);
        w.pts = PW'(cur_len);
        w.inv = cur_inv;
        q.push_back(w);
        pos = (pos + 1) % cur_len;
      end
    end
  end

  initial begin
    int unsigned idx = 0;
    sink_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
        sink_ready = (idx % 4 == 0) || (idx % 4 == 3);
        idx++;
      end else begin
        sink_ready = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t reached, expected end of test earlier", $time);
    $fatal(1, "simulation time limit");
  end

  task automatic send(input int n, input int gap16, input int chg_at,
                      input logic [PW-1:0] chg_pts, input logic chg_inv, output int cycles);
    int acc = 0;
    cycles = 0;
    while (acc < n && cycles < n * 40 + 200) begin
      @(posedge clk);
      #1;
      if (acc == chg_at) begin
        cfg_fftpts  = chg_pts;
        cfg_inverse = chg_inv;
      end
      in_valid = ($urandom_range(15) >= 32'(gap16));
      in_real  = DW'($urandom);
      in_imag  = DW'($urandom);
      @(negedge clk);
      cycles++;
      if (in_valid && in_ready) acc++;
    end
    check("send_count", 64'(acc), 64'(n));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input logic [CW-1:0] exp_frames);
    int k = 0;
    idle(1);
    while (q.size() > 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check({tag, "_drained"}, 64'(q.size()), 64'd0);
    check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_frames));
    check({tag, "_model_frames"}, 64'(frame_cnt), 64'(frames_seen));
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sink_valid"}, 64'(sink_valid), 64'd0);
    check({tag, "_sop_eop"}, 64'({sink_sop, sink_eop}), 64'd0);
    check({tag, "_data"}, 64'({sink_real, sink_imag}), 64'd0);
    check({tag, "_fftpts_in"}, 64'(fftpts_in), 64'd1024);
    check({tag, "_inverse"}, 64'(inverse), 64'd0);
    check({tag, "_cfg_err"}, 64'(cfg_err), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_sink_error"}, 64'(sink_error), 64'd0);
  endtask

  initial begin
    int cyc;
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    cfg_fftpts  = PW'(8);
    cfg_inverse = 1'b0;
    in_real     = '0;
    in_imag     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_rst", 64'(in_ready), 64'd1);

    // 8-point forward frames, continuous stream and sink.
    send(24, 0, -1, '0, 1'b0, cyc);
    check("t1_no_gap_cycles", 64'(cyc), 64'd24);
    drain("t1", CW'(3));

    // 16-point frames with sink_ready toggling 1,0,0,1.
    cfg_fftpts = PW'(16);
    rdy_mode   = 1;
    send(32, 0, -1, '0, 1'b0, cyc);
    drain("t2", CW'(5));
    rdy_mode = 0;

    // Mid-frame config change only affects the following frame.
    send(48, 0, 5, PW'(32), 1'b1, cyc);
    drain("t3", CW'(7));

    // Illegal length blocks frame start until corrected.
    cfg_fftpts  = PW'(12);
    cfg_inverse = 1'b0;
    idle(3);
    repeat (5) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      @(negedge clk);
      check("t4_cfg_err", 64'(cfg_err), 64'd1);
      check("t4_in_ready", 64'(in_ready), 64'd0);
    end
    send(64, 2, 0, PW'(64), 1'b0, cyc);
    drain("t4", CW'(8));
    check("t4_cfg_err_clear", 64'(cfg_err), 64'd0);

    // Reset in the middle of a 64-point frame.
    send(20, 0, -1, '0, 1'b0, cyc);
    @(posedge clk);
    #1;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_reset("t5_rst");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_in_ready", 64'(in_ready), 64'd1);
    check("t5_frame_cnt0", 64'(frame_cnt), 64'd0);
    send(64, 3, -1, '0, 1'b0, cyc);
    drain("t5", CW'(1));

    // Long run of 1024-point frames with random upstream gaps.
    cfg_fftpts = PW'(1024);
    send(70 * 1024, 1, -1, '0, 1'b0, cyc);
    drain("t6", CW'(71));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
